// File: rtl/sseg_pkg.sv
// Shared constants and types for the multiplexed seven-segment scan driver.
package sseg_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low a..g patterns, entry 15 first so SEG_LUT[code] selects the code.
   localparam logic [15:0][6:0] SEG_LUT = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h18, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   typedef enum logic {
      GUARD = 1'b0,
      DRIVE = 1'b1
   } scan_state_t;

   function automatic logic [6:0] seg_lookup(input logic [3:0] code);
      return SEG_LUT[code];
   endfunction

endpackage

// File: rtl/sseg_decode.sv
// Combinational 4-bit code to active-low segment decoder with BCD/hex validity.
module sseg_decode
   import sseg_pkg::*;
(
   input  logic [3:0] code,
   input  logic       hex_mode,
   output logic [6:0] seg_n,
   output logic       valid
);

   always_comb begin
      valid = hex_mode || (code <= 4'd9);
      seg_n = valid ? seg_lookup(code) : SEG_BLANK;
   end

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with shadow registers,
// leading-zero suppression and a per-slot anode guard interval.
module sseg_scan_driver
   import sseg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned REFRESH_DIV  = 50000,
   parameter int unsigned GUARD_CYCLES = 1,
   parameter int unsigned HEX_MODE     = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   en_in,
   input  logic                    lz_suppress,
   output logic [6:0]              seg_n,
   output logic                    dp_n,
   output logic [NUM_DIGITS-1:0]   an_n,
   output logic                    frame_done
);

   localparam int unsigned TICK_W = $clog2(REFRESH_DIV);
   localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REFRESH_DIV - 1);
   localparam logic [TICK_W-1:0] GUARD_END = TICK_W'(GUARD_CYCLES);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
   localparam logic              HEX_EN    = (HEX_MODE != 0);

   logic [3:0]            dig_q [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] dp_q;
   logic [NUM_DIGITS-1:0] en_q;

   logic [TICK_W-1:0]     tick;
   logic [TICK_W-1:0]     tick_next;
   logic [IDX_W-1:0]      idx;
   logic [IDX_W-1:0]      idx_next;
   logic                  tick_wrap;
   logic                  frame_wrap;
   scan_state_t           state;
   scan_state_t           state_next;

   logic [NUM_DIGITS-1:0] lead_zero;
   logic                  zero_run;
   logic [NUM_DIGITS-1:0] an_drive;

   logic [3:0]            cur_code;
   logic                  cur_en;
   logic                  cur_dp;
   logic                  cur_lz;
   logic [6:0]            dec_seg;
   logic                  dec_valid;
   logic                  show;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            dig_q[i] <= '0;
         end
         dp_q <= '0;
         en_q <= '1;
      end else if (load) begin
         for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            dig_q[i] <= digits_in[4*i +: 4];
         end
         dp_q <= dp_in;
         en_q <= en_in;
      end
   end

   // Walk from the leftmost digit down; disabled digits do not end the zero run.
   always_comb begin
      lead_zero = '0;
      zero_run  = 1'b1;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         zero_run = zero_run & (~en_q[NUM_DIGITS-1-k] | (dig_q[NUM_DIGITS-1-k] == 4'd0));
         lead_zero[NUM_DIGITS-1-k] = zero_run;
      end
   end

   always_comb begin
      an_drive = '1;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         an_drive[k] = (idx != IDX_W'(k));
      end
   end

   always_comb begin
      tick_wrap  = (tick == TICK_LAST);
      tick_next  = tick_wrap ? '0 : tick + 1'b1;
      frame_wrap = tick_wrap && (idx == IDX_LAST);
      if (tick_wrap) begin
         idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
         idx_next = idx;
      end
      state_next = (tick_next >= GUARD_END) ? DRIVE : GUARD;
   end

   always_comb begin
      cur_code = dig_q[idx];
      cur_en   = en_q[idx];
      cur_dp   = dp_q[idx];
      cur_lz   = lz_suppress && (idx != '0) && lead_zero[idx];
   end

   sseg_decode u_decode (
      .code     (cur_code),
      .hex_mode (HEX_EN),
      .seg_n    (dec_seg),
      .valid    (dec_valid)
   );

   assign show = cur_en && dec_valid && !cur_lz;

   // State tracks tick so that GUARD covers ticks 0..GUARD_CYCLES-1 of every slot.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tick       <= '0;
         idx        <= '0;
         state      <= GUARD;
         an_n       <= '1;
         seg_n      <= SEG_BLANK;
         dp_n       <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         tick       <= tick_next;
         idx        <= idx_next;
         state      <= state_next;
         frame_done <= frame_wrap;
         case (state)
            DRIVE: begin
               an_n  <= an_drive;
               seg_n <= show ? dec_seg : SEG_BLANK;
               dp_n  <= ~(show && cur_dp);
            end
            default: begin
               an_n  <= '1;
               seg_n <= SEG_BLANK;
               dp_n  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed bench for sseg_scan_driver: a BCD instance and a hex instance share
// all inputs; expected segment patterns are written out per scenario.
module tb_sseg_scan_driver;

   logic        clk;
   logic        rst_n;
   logic        load;
   logic [15:0] digits_in;
   logic [3:0]  dp_in;
   logic [3:0]  en_in;
   logic        lz_suppress;

   logic [6:0]  seg_n;
   logic        dp_n;
   logic [3:0]  an_n;
   logic        frame_done;

   logic [6:0]  seg_n_h;
   logic        dp_n_h;
   logic [3:0]  an_n_h;
   logic        frame_done_h;

   int checks = 0;
   int errors = 0;

   sseg_scan_driver #(
      .NUM_DIGITS   (4),
      .REFRESH_DIV  (4),
      .GUARD_CYCLES (1),
      .HEX_MODE     (0)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (load),
      .digits_in   (digits_in),
      .dp_in       (dp_in),
      .en_in       (en_in),
      .lz_suppress (lz_suppress),
      .seg_n       (seg_n),
      .dp_n        (dp_n),
      .an_n        (an_n),
      .frame_done  (frame_done)
   );

   sseg_scan_driver #(
      .NUM_DIGITS   (4),
      .REFRESH_DIV  (4),
      .GUARD_CYCLES (1),
      .HEX_MODE     (1)
   ) dut_hex (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (load),
      .digits_in   (digits_in),
      .dp_in       (dp_in),
      .en_in       (en_in),
      .lz_suppress (lz_suppress),
      .seg_n       (seg_n_h),
      .dp_n        (dp_n_h),
      .an_n        (an_n_h),
      .frame_done  (frame_done_h)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Loads a pattern at a frame boundary and checks the next full frame.
   // segs/segs_h pack digit 3 in [27:21] down to digit 0 in [6:0].
   task automatic frame_check(input string name, input logic [15:0] dig, input logic [3:0] dp,
                              input logic [3:0] en, input logic lz, input logic [27:0] segs,
                              input logic [27:0] segs_h, input logic [3:0] dpn);
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic [6:0] e_seg_h;
      logic       e_dp;
      int         slot;
      int         ph;
      digits_in   = dig;
      dp_in       = dp;
      en_in       = en;
      lz_suppress = lz;
      load        = 1'b1;
      for (int j = 1; j <= 16; j++) begin
         step();
         load = 1'b0;
         slot = (j - 1) / 4;
         ph   = (j - 1) % 4;
         if (ph == 0) begin
            e_an    = 4'hF;
            e_seg   = 7'h7F;
            e_seg_h = 7'h7F;
            e_dp    = 1'b1;
         end else begin
            e_an    = ~(4'b0001 << slot);
            e_seg   = segs[7*slot +: 7];
            e_seg_h = segs_h[7*slot +: 7];
            e_dp    = dpn[slot];
         end
         chk($sformatf("%s an_n c%0d", name, j), 32'(an_n), 32'(e_an));
         chk($sformatf("%s seg_n c%0d", name, j), 32'(seg_n), 32'(e_seg));
         chk($sformatf("%s seg_n_hex c%0d", name, j), 32'(seg_n_h), 32'(e_seg_h));
         chk($sformatf("%s dp_n c%0d", name, j), 32'(dp_n), 32'(e_dp));
         chk($sformatf("%s frame_done c%0d", name, j), 32'(frame_done), 32'(j == 16));
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      load        = 1'b0;
      digits_in   = '0;
      dp_in       = '0;
      en_in       = '0;
      lz_suppress = 1'b0;

      step();
      step();
      step();
      chk("reset an_n", 32'(an_n), 32'hF);
      chk("reset seg_n", 32'(seg_n), 32'h7F);
      chk("reset dp_n", 32'(dp_n), 32'h1);
      chk("reset frame_done", 32'(frame_done), 32'h0);

      // Release coincides with the first load; digit 0 anode low on the 2nd cycle.
      rst_n = 1'b1;
      frame_check("scan1234", 16'h1234, 4'b0000, 4'hF, 1'b0,
                  {7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111);
      frame_check("dp0101", 16'h1234, 4'b0101, 4'hF, 1'b0,
                  {7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1010);
      frame_check("en1101", 16'h1234, 4'b0010, 4'b1101, 1'b0,
                  {7'h79, 7'h24, 7'h7F, 7'h19}, {7'h79, 7'h24, 7'h7F, 7'h19}, 4'b1111);
      frame_check("lz0007", 16'h0007, 4'b0000, 4'hF, 1'b1,
                  {7'h7F, 7'h7F, 7'h7F, 7'h78}, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 4'b1111);
      frame_check("lz0000", 16'h0000, 4'b0000, 4'hF, 1'b1,
                  {7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111);
      frame_check("lz5007dis", 16'h5007, 4'b0100, 4'b0111, 1'b1,
                  {7'h7F, 7'h7F, 7'h7F, 7'h78}, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 4'b1111);
      frame_check("lz1007", 16'h1007, 4'b0000, 4'hF, 1'b1,
                  {7'h79, 7'h40, 7'h40, 7'h78}, {7'h79, 7'h40, 7'h40, 7'h78}, 4'b1111);
      frame_check("hexFA5B", 16'hFA5B, 4'b0000, 4'hF, 1'b0,
                  {7'h7F, 7'h7F, 7'h12, 7'h7F}, {7'h0E, 7'h08, 7'h12, 7'h03}, 4'b1111);
      frame_check("base1234", 16'h1234, 4'b0000, 4'hF, 1'b0,
                  {7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111);

      // Load during the 2nd DRIVE cycle of digit 0.
      step();
      chk("mid guard an_n", 32'(an_n), 32'hF);
      step();
      chk("mid d0 an_n", 32'(an_n), 32'hE);
      chk("mid d0 seg_n", 32'(seg_n), 32'h19);
      digits_in = 16'h1238;
      load      = 1'b1;
      step();
      load = 1'b0;
      chk("mid load-cycle seg_n", 32'(seg_n), 32'h19);
      step();
      chk("mid after-load an_n", 32'(an_n), 32'hE);
      chk("mid after-load seg_n", 32'(seg_n), 32'h00);
      chk("mid after-load seg_n_hex", 32'(seg_n_h), 32'h00);
      step();
      chk("mid d1 guard an_n", 32'(an_n), 32'hF);
      step();
      chk("mid d1 an_n", 32'(an_n), 32'hD);
      chk("mid d1 seg_n", 32'(seg_n), 32'h30);

      // Mid-slot reset, with load asserted to confirm reset wins.
      rst_n     = 1'b0;
      load      = 1'b1;
      digits_in = 16'h9999;
      step();
      chk("midrst an_n", 32'(an_n), 32'hF);
      chk("midrst seg_n", 32'(seg_n), 32'h7F);
      chk("midrst dp_n", 32'(dp_n), 32'h1);
      chk("midrst frame_done", 32'(frame_done), 32'h0);
      step();
      step();
      rst_n       = 1'b1;
      load        = 1'b0;
      lz_suppress = 1'b0;
      step();
      chk("postrst guard an_n", 32'(an_n), 32'hF);
      step();
      chk("postrst an_n", 32'(an_n), 32'hE);
      chk("postrst seg_n", 32'(seg_n), 32'h40);
      chk("postrst seg_n_hex", 32'(seg_n_h), 32'h40);
      chk("postrst dp_n", 32'(dp_n), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sseg_scan_driver.md
# sseg_scan_driver

Parametrised multiplexed seven-segment display driver. It time-multiplexes `NUM_DIGITS` active-low common-anode digits from one shared segment bus. Each digit is decoded from a 4-bit code in BCD or hex mode, with per-digit enable, per-digit decimal point, leading-zero suppression and an anode guard interval against ghosting. It sits between switch- or counter-driven datapaths and the board's `sseg`/`an` pins, replacing single-digit static decoders.

## Interface
- `NUM_DIGITS`, 4: digits scanned; 1..8.
- `REFRESH_DIV`, 50000: clock cycles per digit slot; ≥ 2.
- `GUARD_CYCLES`, 1: cycles at slot start with all anodes off; < `REFRESH_DIV`.
- `HEX_MODE`, 0: 0 means codes 10..15 render blank; 1 means they render A–F.
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous, active-low reset.
- `load` in 1: strobe; captures `digits_in`, `dp_in`, `en_in` on the same edge.
- `digits_in` in 4*NUM_DIGITS: digit i is `[4i+3:4i]`; digit 0 is rightmost.
- `dp_in` in NUM_DIGITS: 1 lights the decimal point of digit i.
- `en_in` in NUM_DIGITS: 0 blanks digit i entirely, including its dp.
- `lz_suppress` in 1: live level; 1 blanks leading zeros.
- `seg_n` out 7: segments a..g on bits 0..6, active-low.
- `dp_n` out 1: decimal point, active-low.
- `an_n` out NUM_DIGITS: anode selects, active-low, at most one low at a time.
- `frame_done` out 1: one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to 0.

## Operation
- **Shadow registers.** `load`=1 writes the shadow registers `dig_q`, `dp_q`, `en_q`; otherwise they hold. Shadow contents appear on the outputs one cycle after the load edge if the current slot's digit changed.
- **Tick counter.** `tick` counts 0..REFRESH_DIV-1 and wraps to 0. On wrap, `idx` advances: `idx` = NUM_DIGITS-1 wraps to 0 and asserts `frame_done` in the following cycle.
- **Scan FSM, state GUARD.** Entered when `tick`=0. `an_n` is all 1, `seg_n`=7'h7F, `dp_n`=1. Moves to DRIVE when `tick`=GUARD_CYCLES.
- **Scan FSM, state DRIVE.** `an_n[idx]`=0 and all other anodes are 1. `seg_n` = decode(`dig_q[idx]`). `dp_n` = ~`dp_q[idx]`.
- **Blanking.** A digit is blanked (`seg_n`=7'h7F, `dp_n`=1, anode still driven) if any of these holds:
  - `en_q[idx]`=0;
  - `HEX_MODE`=0 and the code is > 9;
  - `lz_suppress`=1, `idx` > 0, and every enabled digit from NUM_DIGITS-1 down to `idx` is code 0.
- **Digit 0 and leading zeros.** Digit 0 is never leading-zero suppressed. Decimal points on suppressed digits are also blanked.
- **Decode patterns.** The codes match the existing static decoder:
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19
  - 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h18
  - A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E
- **Reset.** While `rst_n`=0 at a clock edge:
  - `tick`, `idx`, `dig_q`, `dp_q` ← 0;
  - `en_q` ← all 1;
  - state ← GUARD.
  
  From that edge, `an_n` is all 1, `seg_n`=7'h7F, `dp_n`=1 and `frame_done`=0. Reset in mid-slot aborts the slot with no partial pulse. Reset takes priority over `load`.

## Timing
- All outputs are registered, with one-cycle latency from `tick`/`idx`/shadow to the pins.
- Slot length is exactly REFRESH_DIV cycles. Anode-low time per slot is REFRESH_DIV-GUARD_CYCLES. Frame length is NUM_DIGITS*REFRESH_DIV.
- First anode goes low GUARD_CYCLES+1 cycles after reset deassertion.
- `load` coincident with a slot boundary takes effect in the new slot's first DRIVE cycle.
- `load` is accepted every cycle; there is no back-pressure.
- `lz_suppress` changes take effect on the next output register update.

## Structure
- **Package `sseg_pkg`.** Holds:
  - `SEG_BLANK` = 7'h7F;
  - a 16-entry `SEG_LUT` of the patterns above;
  - the enumerated scan state type {GUARD, DRIVE}.
- **Sub-module `sseg_decode`.** Combinational: code (4) and `hex_mode` in, `seg_n` (7) and `valid` out. It is instantiated once on the muxed digit.

## Test plan
- NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=1 for all scenarios below.
- **Reset values:** hold `rst_n`=0 for 3 cycles → `an_n`=4'hF, `seg_n`=7'h7F, `dp_n`=1, `frame_done`=0. The first `an_n`=4'hE appears 2 cycles after release.
- **Scan and pulse:** load `digits_in`=16'h1234 and `en_in`=4'hF, then run 16 cycles. Each slot shows `an_n` 4'hF, then 3 cycles of the digit's anode. The sequence is 4'hE/7'h19, 4'hD/7'h30, 4'hB/7'h24, 4'h7/7'h79. `frame_done` pulses once per 16 cycles.
- **Leading-zero suppression:** `digits_in`=16'h0007 with `lz_suppress`=1 → digits 3..1 show 7'h7F and digit 0 shows 7'h78. With `digits_in`=16'h0000, only digit 0 shows 7'h40.
- **BCD invalid vs hex:** code 4'hA with HEX_MODE=0 → 7'h7F. The same code with HEX_MODE=1 → 7'h08.
- **Decimal point and enable:** `dp_in`=4'b0010, `en_in`=4'b1101 → `dp_n`=0 only in digit 1's slot is overridden, because digit 1 is disabled. Digit 1's slot shows `seg_n`=7'h7F and `dp_n`=1.
- **Load mid-slot and reset mid-slot:**
  - `load` in the 2nd DRIVE cycle of digit 0 → the new pattern appears on the following cycle.
  - `rst_n`=0 mid-slot → `an_n`=4'hF the next cycle.
